// File: rtl/symbol_packer_if.sv
// Byte-in / symbol-out bundle between the payload source, the packer and the nibble demux.
// master drives bytes and frame start; slave returns ready and the symbol stream.
interface symbol_packer_if;
    logic [7:0] inByte;
    logic       inValid;
    logic       outReady;
    logic       inStart;
    logic [3:0] outData;
    logic [1:0] outSel;
    logic       outValid;
    logic       outWordDone;

    modport master (
        output inByte, inValid, inStart,
        input  outReady, outData, outSel, outValid, outWordDone
    );

    modport slave (
        input  inByte, inValid, inStart,
        output outReady, outData, outSel, outValid, outWordDone
    );
endinterface

// File: rtl/symbol_packer.sv
// Small synchronous FIFO with a flush that may coincide with a push (the push lands as entry 0).
// Latency: a pushed word is poppable the cycle after the push; push_rdy is registered from next count.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_n, rd_n, wr_addr;
    logic [PTR_W:0]   cnt, cnt_n;
    logic             rdy_q;

    always_comb begin
        wr_n    = wr_ptr;
        rd_n    = rd_ptr;
        cnt_n   = cnt;
        wr_addr = wr_ptr;
        if (clr) begin
            rd_n    = '0;
            wr_addr = '0;
            wr_n    = push ? PTR_W'(1) : '0;
            cnt_n   = push ? (PTR_W+1)'(1) : '0;
        end else begin
            if (push) wr_n = wr_ptr + PTR_W'(1);
            if (pop)  rd_n = rd_ptr + PTR_W'(1);
            cnt_n = cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rdy_q  <= 1'b0;
        end else begin
            wr_ptr <= wr_n;
            rd_ptr <= rd_n;
            cnt    <= cnt_n;
            rdy_q  <= (cnt_n != (PTR_W+1)'(DEPTH));
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_addr] <= push_dat;
    end

    assign pop_dat  = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign push_rdy = rdy_q;
endmodule

// Packs buffered payload bytes into a low-nibble-first symbol stream tagged with a 2-bit slot.
// Latency: byte accepted at edge k -> low nibble after k+2, high after k+3; backpressure only via outReady (FIFO full).
module symbol_packer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic            inClock,
    input  logic            inReset,
    symbol_packer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t     state_q, state_n;
    logic [7:0] byte_q;
    logic [1:0] slot_q;
    logic [3:0] data_q;
    logic [1:0] sel_q;
    logic       vld_q;
    logic       wd_q;

    logic       push, pop, fifo_empty, fifo_rdy, emit;
    logic [7:0] fifo_dat;
    logic [3:0] nibble;

    assign push = bus.inValid & fifo_rdy;

    sync_fifo #(.W(8), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk      (inClock),
        .rst_n    (inReset),
        .clr      (bus.inStart),
        .push     (push),
        .push_dat (bus.inByte),
        .push_rdy (fifo_rdy),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_n = state_q;
        pop     = 1'b0;
        emit    = 1'b0;
        nibble  = byte_q[3:0];
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = LOW;
                end
            end
            LOW: begin
                emit    = 1'b1;
                state_n = HIGH;
            end
            HIGH: begin
                emit   = 1'b1;
                nibble = byte_q[7:4];
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = LOW;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A frame start abandons whatever byte is in flight.
        if (bus.inStart) begin
            pop     = 1'b0;
            emit    = 1'b0;
            state_n = IDLE;
        end
    end

    always_ff @(posedge inClock) begin
        if (!inReset) begin
            state_q <= IDLE;
            byte_q  <= '0;
            slot_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            vld_q   <= emit;
            wd_q    <= emit && (slot_q == 2'd3);
            if (pop) byte_q <= fifo_dat;
            if (emit) begin
                data_q <= nibble;
                sel_q  <= slot_q;
                slot_q <= slot_q + 2'd1;
            end
            if (bus.inStart) slot_q <= '0;
        end
    end

    assign bus.outReady    = fifo_rdy;
    assign bus.outData     = data_q;
    assign bus.outSel      = sel_q;
    assign bus.outValid    = vld_q;
    assign bus.outWordDone = wd_q;
endmodule

// File: tb/tb_symbol_packer.sv
// Directed bench for symbol_packer: stimulus queues expected symbols, a monitor pops and compares them.
module tb_symbol_packer;
    logic inClock = 1'b0;
    logic inReset = 1'b0;
    always #5 inClock = ~inClock;

    symbol_packer_if bus();

    symbol_packer #(.DEPTH(4), .PTR_W(2)) dut (
        .inClock (inClock),
        .inReset (inReset),
        .bus     (bus.slave)
    );

    int         total = 0;
    int         bad   = 0;
    logic [6:0] exp_q[$];
    logic       saw_full;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_sym(input logic [3:0] d, input logic [1:0] s);
        exp_q.push_back({d, s, (s == 2'd3)});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge inClock);
            #1;
        end
    endtask

    // Holds the byte until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.inByte  = b;
        bus.inValid = 1'b1;
        while (bus.outReady !== 1'b1 && n < 50) begin
            saw_full = 1'b1;
            tick(1);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'd0);
        tick(1);
    endtask

    task automatic start_frame();
        bus.inValid = 1'b0;
        bus.inStart = 1'b1;
        tick(1);
        bus.inStart = 1'b0;
        check("start_vld", 32'(bus.outValid), 32'd0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge inClock) begin
        if (inReset === 1'b1) begin
            if (bus.outValid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_symbol: got %0h/%0d want none at %0t",
                             bus.outData, bus.outSel, $time);
                end else begin
                    check("symbol", 32'({bus.outData, bus.outSel, bus.outWordDone}), 32'(exp_q.pop_front()));
                end
            end else begin
                check("wd_idle", 32'(bus.outWordDone), 32'd0);
            end
        end
    end

    initial begin
        logic [7:0] burst [8];
        burst = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
        saw_full    = 1'b0;
        bus.inByte  = 8'hFF;
        bus.inValid = 1'b1;
        bus.inStart = 1'b0;

        // Reset held with a byte offered: nothing may be stored.
        tick(4);
        check("rst_vld", 32'(bus.outValid), 32'd0);
        check("rst_data", 32'(bus.outData), 32'd0);
        check("rst_sel", 32'(bus.outSel), 32'd0);
        check("rst_wd", 32'(bus.outWordDone), 32'd0);
        check("rst_rdy", 32'(bus.outReady), 32'd0);
        inReset     = 1'b1;
        bus.inValid = 1'b0;
        tick(1);
        check("rdy_after_rst", 32'(bus.outReady), 32'd1);
        tick(3);
        check("no_stored_byte", 32'(bus.outValid), 32'd0);

        // Single byte latency and hold behaviour.
        expect_sym(4'h5, 2'd0);
        expect_sym(4'hA, 2'd1);
        send(8'hA5);
        bus.inValid = 1'b0;
        tick(1);
        check("single_k1_vld", 32'(bus.outValid), 32'd0);
        tick(1);
        check("single_k2_vld", 32'(bus.outValid), 32'd1);
        check("single_k2_data", 32'(bus.outData), 32'h5);
        tick(1);
        check("single_k3_data", 32'(bus.outData), 32'hA);
        tick(1);
        check("single_k4_vld", 32'(bus.outValid), 32'd0);
        check("single_k4_sel", 32'(bus.outSel), 32'd1);

        // Back-to-back word.
        start_frame();
        expect_sym(4'h1, 2'd0);
        expect_sym(4'h2, 2'd1);
        expect_sym(4'h3, 2'd2);
        expect_sym(4'h4, 2'd3);
        send(8'h21);
        send(8'h43);
        bus.inValid = 1'b0;
        drain("word_drain");

        // Burst that fills the FIFO.
        start_frame();
        for (int i = 0; i < 8; i++) begin
            expect_sym(burst[i][3:0], 2'((2 * i) % 4));
            expect_sym(burst[i][7:4], 2'((2 * i + 1) % 4));
        end
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) send(burst[i]);
        bus.inValid = 1'b0;
        check("burst_full_seen", 32'(saw_full), 32'd1);
        drain("burst_drain");

        // Frame start mid-byte with a new byte in the same cycle.
        start_frame();
        expect_sym(4'h7, 2'd0);
        expect_sym(4'hC, 2'd0);
        expect_sym(4'h3, 2'd1);
        send(8'h77);
        send(8'h88);
        bus.inValid = 1'b0;
        tick(1);
        check("flush_low_vld", 32'(bus.outValid), 32'd1);
        check("flush_low_data", 32'(bus.outData), 32'h7);
        bus.inStart = 1'b1;
        bus.inValid = 1'b1;
        bus.inByte  = 8'h3C;
        tick(1);
        bus.inStart = 1'b0;
        bus.inValid = 1'b0;
        check("flush_vld", 32'(bus.outValid), 32'd0);
        drain("flush_drain");

        // Starvation: slot resumes where it stopped.
        start_frame();
        expect_sym(4'h0, 2'd0);
        expect_sym(4'h1, 2'd1);
        expect_sym(4'h2, 2'd2);
        expect_sym(4'h3, 2'd3);
        send(8'h10);
        bus.inValid = 1'b0;
        tick(3);
        send(8'h32);
        bus.inValid = 1'b0;
        check("gap_vld_a", 32'(bus.outValid), 32'd0);
        tick(1);
        check("gap_vld_b", 32'(bus.outValid), 32'd0);
        tick(1);
        check("resume_vld", 32'(bus.outValid), 32'd1);
        check("resume_sel", 32'(bus.outSel), 32'd2);
        drain("starve_drain");

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
